// File: rtl/imm_extend_stage.sv
// imm_extend_stage: registered zero/sign immediate extension with optional fixed left shift and a one-entry skid buffer
module imm_extend_stage #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 8,
    parameter int SHL   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
);
    generate
        if (IN_W < 1 || OUT_W < IN_W + SHL) begin : g_bad_width
            $error("imm_extend_stage: need IN_W >= 1 and OUT_W >= IN_W + SHL");
        end
    endgenerate

    logic [OUT_W-1:0] zx, sx, ext, result, skid_data;
    logic             skid_valid, accept, load;

    assign zx = OUT_W'(in_imm);
    assign sx = OUT_W'($signed(in_imm));

    always_comb begin
        ext    = in_mode[0] ? sx : zx;
        result = in_mode[1] ? ext << SHL : ext;
        accept = in_valid & in_ready;
        load   = ~out_valid | out_ready;
    end

    // ready comes straight from the skid flop, so no combinational path from out_ready
    assign in_ready = ~skid_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (load) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= accept;
                if (accept) out_data <= result;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_data  <= result;
        end
    end
endmodule
